// File: rtl/mem_responder_pkg.sv
// Shared types and limits for the memory responder: FSM states, access op,
// and the legal range of the access latency.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between datapath control (MAR/MDR side) and the
// memory responder.
interface mem_responder_if;

  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        err;

  modport master (
    output read, write, addr, wdata,
    input  rdata, done, busy, err
  );

  modport slave (
    input  read, write, addr, wdata,
    output rdata, done, busy, err
  );

endinterface

// File: rtl/mem_responder_sram_array.sv
// Single-port word array: synchronous write, synchronous read into an output
// register that holds until the next read enable.
module sram_array #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [2**ADDR_W];

  // NOTE: storage and its read register are deliberately left without reset so
  // the array maps onto RAM macros and survives a responder reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: captures a read/write request, counts out
// LATENCY edges, performs the array access and pulses done (with err).
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             clr,
  mem_responder_if.slave   bus
);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 1..15");
  end

  state_t           state;
  op_t              op_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             done_q;
  logic             busy_q;
  logic             err_q;
  logic             rd_valid;
  logic [31:0]      mem_q;
  logic             in_range;
  logic             access;
  logic             mem_we;
  logic             mem_re;

  assign in_range = (addr_q[31:ADDR_W] == '0);
  assign access   = (state == ACCESS) && (cnt == '0);
  assign mem_we   = access && (op_q == OP_WR) && in_range;
  assign mem_re   = access && (op_q == OP_RD) && in_range;

  sram_array #(
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_q[ADDR_W-1:0]),
    .wdata (wdata_q),
    .q     (mem_q)
  );

  // NOTE: every state register here uses <= so all updates see pre-edge values;
  // done/err default low each edge so they can only ever pulse for one cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      op_q     <= OP_RD;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.read && bus.write) begin
            state  <= DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
            busy_q <= 1'b1;
          end else if (bus.read || bus.write) begin
            op_q    <= bus.write ? OP_WR : OP_RD;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= ACCESS;
            busy_q  <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
            err_q  <= !in_range;
            // An out-of-range read forces rdata to zero until the next good read.
            if (op_q == OP_RD) begin
              rd_valid <= in_range;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // rdata is a gated view of the array's read register, so it is still fed
  // only by flops and never by the request inputs.
  assign bus.rdata = rd_valid ? mem_q : '0;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=2 instance for the functional
// and reset cases, one LATENCY=1 instance for back-to-back reads.
module tb_mem_responder;

  logic clk;
  logic clr;

  int n_cmp;
  int n_err;

  mem_responder_if b ();
  mem_responder_if c ();

  mem_responder #(.ADDR_W(9), .LATENCY(2)) dut2 (
    .clk (clk),
    .clr (clr),
    .bus (b)
  );

  mem_responder #(.ADDR_W(9), .LATENCY(1)) dut1 (
    .clk (clk),
    .clr (clr),
    .bus (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {done, busy, err} of either instance
  function automatic logic [31:0] flags(input bit sel);
    return sel ? {29'd0, c.done, c.busy, c.err} : {29'd0, b.done, b.busy, b.err};
  endfunction

  // Present one request for exactly one rising edge (E0); returns at E0 + half a cycle.
  task automatic req(input bit sel, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    if (sel) begin
      c.read = r; c.write = w; c.addr = a; c.wdata = d;
    end else begin
      b.read = r; b.write = w; b.addr = a; b.wdata = d;
    end
    @(negedge clk);
    if (sel) begin
      c.read = 1'b0; c.write = 1'b0;
    end else begin
      b.read = 1'b0; b.write = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] vals [3];
    vals = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
    n_cmp = 0;
    n_err = 0;
    b.read = 1'b0; b.write = 1'b0; b.addr = '0; b.wdata = '0;
    c.read = 1'b0; c.write = 1'b0; c.addr = '0; c.wdata = '0;
    clr = 1'b1;
    #1 clr = 1'b0;
    #2;
    check("reset_rdata", b.rdata, 32'h0);
    check("reset_flags", flags(0), 32'h0);
    @(negedge clk);
    clr = 1'b1;

    // write DEADBEEF to 5, LATENCY=2
    req(0, 1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    check("wr_e0_flags", flags(0), 32'b010);
    @(negedge clk);
    check("wr_e1_flags", flags(0), 32'b010);
    @(negedge clk);
    check("wr_e2_done", flags(0), 32'b110);
    check("wr_rdata_untouched", b.rdata, 32'h0);
    @(negedge clk);
    check("wr_e3_idle", flags(0), 32'b000);

    // read back address 5
    req(0, 1'b1, 1'b0, 32'd5, 32'h0);
    @(negedge clk);
    check("rd_e1_flags", flags(0), 32'b010);
    @(negedge clk);
    check("rd_e2_done", flags(0), 32'b110);
    check("rd_e2_data", b.rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("rd_e3_idle", flags(0), 32'b000);
    check("rd_hold", b.rdata, 32'hDEAD_BEEF);

    // address 0 and address 7 seeded for later steps
    req(0, 1'b0, 1'b1, 32'd0, 32'hCAFE_0000);
    repeat (3) @(negedge clk);
    req(0, 1'b0, 1'b1, 32'd7, 32'h0000_1234);
    repeat (3) @(negedge clk);

    // out-of-range read
    req(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    repeat (2) @(negedge clk);
    check("oor_flags", flags(0), 32'b111);
    check("oor_rdata", b.rdata, 32'h0);
    @(negedge clk);
    check("oor_err_clears", flags(0), 32'b000);
    req(0, 1'b1, 1'b0, 32'd0, 32'h0);
    repeat (2) @(negedge clk);
    check("rd0_after_oor", b.rdata, 32'hCAFE_0000);
    check("rd0_flags", flags(0), 32'b110);
    @(negedge clk);

    // read+write collision
    req(0, 1'b1, 1'b1, 32'd5, 32'h1111_1111);
    check("coll_flags", flags(0), 32'b111);
    check("coll_rdata", b.rdata, 32'hCAFE_0000);
    @(negedge clk);
    check("coll_idle", flags(0), 32'b000);
    req(0, 1'b1, 1'b0, 32'd5, 32'h0);
    repeat (2) @(negedge clk);
    check("coll_array_kept", b.rdata, 32'hDEAD_BEEF);
    @(negedge clk);

    // input changes after capture are ignored
    @(negedge clk);
    b.read = 1'b1; b.addr = 32'd0;
    @(negedge clk);
    b.read = 1'b0; b.addr = 32'd7;
    check("hold_e0_busy", flags(0), 32'b010);
    @(negedge clk);
    b.read = 1'b1; b.addr = 32'h0000_0200;
    check("hold_e1_busy", flags(0), 32'b010);
    @(negedge clk);
    check("hold_done_flags", flags(0), 32'b110);
    check("hold_orig_addr", b.rdata, 32'hCAFE_0000);
    b.read = 1'b0;
    @(negedge clk);
    check("hold_no_recapture", flags(0), 32'b000);
    check("hold_rdata_kept", b.rdata, 32'hCAFE_0000);

    // reset in the middle of a write to 7
    req(0, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 clr = 1'b0;
    #1;
    check("midrst_rdata", b.rdata, 32'h0);
    check("midrst_flags", flags(0), 32'b000);
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_still_idle", flags(0), 32'b000);
    req(0, 1'b1, 1'b0, 32'd7, 32'h0);
    repeat (2) @(negedge clk);
    check("midrst_write_dropped", b.rdata, 32'h0000_1234);
    @(negedge clk);

    // LATENCY=1: seed 1..3, then back-to-back reads with read held high
    for (int i = 0; i < 3; i++) begin
      req(1, 1'b0, 1'b1, 32'(i + 1), vals[i]);
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    c.read = 1'b1; c.addr = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("b2b%0d_capture", i), flags(1), 32'b010);
      @(negedge clk);
      check($sformatf("b2b%0d_done", i), flags(1), 32'b110);
      check($sformatf("b2b%0d_data", i), c.rdata, vals[i]);
      if (i < 2) c.addr = 32'(i + 2);
      else       c.read = 1'b0;
      @(negedge clk);
      check($sformatf("b2b%0d_gap", i), flags(1), 32'b000);
    end
    @(negedge clk);
    check("b2b_stops", flags(1), 32'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
